// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage running one load/store over a req/ack data-memory handshake.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W = 7
) (
    input  logic        clkIn,
    input  logic        reset,
    input  logic        validIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic [2:0]  funct3In,
    input  logic [31:0] addrIn,
    input  logic [31:0] storeDataIn,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memWstrb,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic        stallOut,
    output logic        doneOut,
    output logic [31:0] loadDataOut,
    output logic        faultOut,
    output logic        timeoutOut
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0] f3;
    logic [1:0] lane;
    logic fault_p, to_p, start, illegal, last;
    logic [3:0] strb;
    logic [31:0] wdata, shifted, ext;
    always_comb begin
        start = validIn & (memReadIn | memWriteIn);
        illegal = (memReadIn & memWriteIn)
                | (memReadIn & (funct3In[1:0] == 2'b11 | funct3In == 3'b110))
                | (memWriteIn & (funct3In[2] | funct3In[1:0] == 2'b11))
                | (funct3In[1:0] == 2'b01 & addrIn[0])
                | (funct3In[1:0] == 2'b10 & addrIn[1:0] != 2'b00);
        strb = funct3In[1:0] == 2'b00 ? 4'b0001 << addrIn[1:0] :
               funct3In[1:0] == 2'b01 ? 4'b0011 << addrIn[1:0] : 4'b1111;
        wdata = funct3In[1:0] == 2'b00 ? {4{storeDataIn[7:0]}} :
                funct3In[1:0] == 2'b01 ? {2{storeDataIn[15:0]}} : storeDataIn;
        last = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
        // Byte/half lanes are brought down to bit 0 before extension
        shifted = memRdata >> {lane, 3'b000};
        ext = f3[1:0] == 2'b00 ? {{24{~f3[2] & shifted[7]}}, shifted[7:0]} :
              f3[1:0] == 2'b01 ? {{16{~f3[2] & shifted[15]}}, shifted[15:0]} : memRdata;
        state_nxt = state == IDLE ? (start ? (illegal ? RESP : WAIT) : IDLE) :
                    state == WAIT ? ((memAck | last) ? RESP : WAIT) : IDLE;
        stallOut = (state == IDLE & start) | state == WAIT;
        doneOut = state == RESP;
        faultOut = doneOut & fault_p;
        timeoutOut = doneOut & to_p;
    end
    always_ff @(posedge clkIn) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            memReq <= 1'b0;
            memWe <= 1'b0;
            memAddr <= '0;
            memWdata <= '0;
            memWstrb <= '0;
            loadDataOut <= '0;
            fault_p <= 1'b0;
            to_p <= 1'b0;
            f3 <= '0;
            lane <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                fault_p <= illegal;
                to_p <= 1'b0;
                if (!illegal) begin
                    memReq <= 1'b1;
                    memWe <= memWriteIn;
                    memAddr <= {addrIn[31:2], 2'b00};
                    memWdata <= memWriteIn ? wdata : '0;
                    memWstrb <= memWriteIn ? strb : 4'b0000;
                    f3 <= funct3In;
                    lane <= addrIn[1:0];
                    cnt <= '0;
                end
            end
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (memAck | last) memReq <= 1'b0;
                if (memAck & ~memWe) loadDataOut <= ext;
                if (~memAck & last) to_p <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed plus randomized checks of mem_access_stage against a byte-level model.
module tb_mem_access_stage;
    localparam int TO = 64;
    logic clkIn = 1'b0;
    logic reset, validIn, memReadIn, memWriteIn, memAck;
    logic [2:0] funct3In;
    logic [31:0] addrIn, storeDataIn, memRdata;
    logic memReq, memWe, stallOut, doneOut, faultOut, timeoutOut;
    logic [31:0] memAddr, memWdata, loadDataOut;
    logic [3:0] memWstrb;
    int checks = 0, failures = 0;
    logic [31:0] exp_ld = '0;

    always #5 clkIn = ~clkIn;

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clkIn(clkIn), .reset(reset), .validIn(validIn), .memReadIn(memReadIn),
        .memWriteIn(memWriteIn), .funct3In(funct3In), .addrIn(addrIn),
        .storeDataIn(storeDataIn), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWdata(memWdata), .memWstrb(memWstrb), .memRdata(memRdata), .memAck(memAck),
        .stallOut(stallOut), .doneOut(doneOut), .loadDataOut(loadDataOut),
        .faultOut(faultOut), .timeoutOut(timeoutOut)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clkIn);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legal(input bit rd, input bit wr, input logic [2:0] f, input int a);
        if (rd && wr) return 0;
        if (rd && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (wr && !(f inside {3'd0, 3'd1, 3'd2})) return 0;
        return (a % nbytes(f)) == 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f, input int a, input logic [31:0] rd);
        int n = nbytes(f);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(rd[8*(a+i) +: 8]) << (8*i);
        if (!f[2] && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
        return v[31:0];
    endfunction

    function automatic logic [3:0] strb_of(input logic [2:0] f, input int a);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = (i >= a) && (i < a + nbytes(f));
        return s;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] f, input logic [31:0] sd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nbytes(f)) +: 8];
        return w;
    endfunction

    task automatic access(input bit rd, input bit wr, input logic [2:0] f, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rdata, input int delay);
        bit ok = legal(rd, wr, f, int'(addr[1:0]));
        bit acked = 0;
        logic [3:0] es = wr ? strb_of(f, int'(addr[1:0])) : 4'b0000;
        validIn = 1; memReadIn = rd; memWriteIn = wr; funct3In = f;
        addrIn = addr; storeDataIn = sd; memAck = 0;
        #1;
        chk("accept_stall", stallOut, 1);
        chk("accept_done", doneOut, 0);
        step();
        validIn = 0; memReadIn = 0; memWriteIn = 0; addrIn = $urandom; storeDataIn = $urandom;
        if (!ok) begin
            chk("fault_done", doneOut, 1);
            chk("fault_flag", faultOut, 1);
            chk("fault_timeout", timeoutOut, 0);
            chk("fault_req", memReq, 0);
            chk("fault_stall", stallOut, 0);
            chk("fault_load", loadDataOut, exp_ld);
        end else begin
            for (int w = 0; w < TO && !acked; w++) begin
                chk("wait_stall", stallOut, 1);
                chk("wait_req", memReq, 1);
                chk("wait_we", memWe, wr);
                chk("wait_addr", memAddr, {addr[31:2], 2'b00});
                chk("wait_strb", memWstrb, es);
                if (wr) chk("wait_wdata", memWdata, wdata_of(f, sd));
                chk("wait_done", doneOut, 0);
                acked = (w == delay);
                memAck = acked;
                memRdata = acked ? rdata : $urandom;
                step();
                memAck = 0; memRdata = $urandom;
            end
            if (acked && rd) exp_ld = load_val(f, int'(addr[1:0]), rdata);
            chk("resp_done", doneOut, 1);
            chk("resp_timeout", timeoutOut, !acked);
            chk("resp_fault", faultOut, 0);
            chk("resp_req", memReq, 0);
            chk("resp_stall", stallOut, 0);
            chk("resp_load", loadDataOut, exp_ld);
        end
        step();
        chk("post_done", doneOut, 0);
        memAck = 1'($urandom);
        step();
        memAck = 0;
        chk("idle_ack_done", doneOut, 0);
        chk("idle_req", memReq, 0);
    endtask

    initial begin
        reset = 1; validIn = 0; memReadIn = 0; memWriteIn = 0; funct3In = 0;
        addrIn = 0; storeDataIn = 0; memRdata = 0; memAck = 0;
        step(); step();
        reset = 0;
        chk("rst_req", memReq, 0);
        chk("rst_we", memWe, 0);
        chk("rst_addr", memAddr, 0);
        chk("rst_wdata", memWdata, 0);
        chk("rst_strb", memWstrb, 0);
        chk("rst_done", doneOut, 0);
        chk("rst_load", loadDataOut, 0);
        chk("rst_stall", stallOut, 0);
        access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
        chk("lw_const", loadDataOut, 32'hDEADBEEF);
        access(1, 0, 3'b000, 32'h103, 0, 32'h80FF0011, 2);
        chk("lb_const", loadDataOut, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h103, 0, 32'h80FF0011, 1);
        chk("lbu_const", loadDataOut, 32'h00000080);
        access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, $urandom, 5);
        chk("sh_wdata_const", memWdata, 32'hABCDABCD);
        chk("sh_strb_const", memWstrb, 4'b1100);
        chk("sh_keeps_load", loadDataOut, 32'h00000080);
        access(1, 0, 3'b010, 32'h101, 0, $urandom, 0);
        access(1, 1, 3'b010, 32'h200, 0, $urandom, 0);
        access(1, 0, 3'b010, 32'h40, 0, $urandom, 1000);
        access(1, 0, 3'b101, 32'h2, 0, 32'h8001_7FFF, 3);
        access(0, 1, 3'b000, 32'h3, 32'h55, $urandom, 0);
        access(0, 1, 3'b100, 32'h0, 32'h55, $urandom, 0);
        for (int k = 0; k < 40; k++) begin
            int kind = $urandom_range(0, 9);
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            access(kind == 0 || kind > 5, kind <= 5, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                   $urandom_range(0, 15) == 0 ? 1000 : $urandom_range(0, 6));
        end
        validIn = 1; memReadIn = 1; funct3In = 3'b010; addrIn = 32'h40;
        step();
        validIn = 0; memReadIn = 0;
        step();
        reset = 1;
        step();
        reset = 0;
        exp_ld = '0;
        chk("midrst_req", memReq, 0);
        chk("midrst_addr", memAddr, 0);
        chk("midrst_load", loadDataOut, exp_ld);
        chk("midrst_stall", stallOut, 0);
        memAck = 1; memRdata = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            chk("midrst_no_done", doneOut, 0);
            step();
        end
        chk("midrst_load_after", loadDataOut, exp_ld);
        memAck = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
